// File: rtl/matrix_key_scanner.sv
// matrix_key_scanner: column-scanned key matrix with per-key debounce counters.
// Define KEY_EVENT_FIFO_EN to build the press/release event FIFO and overflow flag.
module matrix_key_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int SETTLE_CYC     = 8,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-1:0]               row,
  output logic [COLS-1:0]               col,
  output logic [ROWS*COLS-1:0]          keys,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(ROWS*COLS)-1:0]  evt_code,
  output logic                          evt_press,
  output logic                          ovf,
  input  logic                          ovf_clr
);
  localparam int N  = ROWS * COLS;
  localparam int KW = $clog2(N);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SETTLE_CYC);
  typedef enum logic [1:0] {IDLE, DRIVE, UPDATE} state_t;
  state_t          r_state;
  logic [CW-1:0]   r_c;
  logic [SW-1:0]   r_set;
  logic [KW-1:0]   r_k;
  logic [N-1:0]    r_raw;
  logic [N-1:0]    r_keys;
  logic [3:0]      r_cnt [N];
  logic [COLS-1:0] r_col;
  logic            w_flip;
  // the key under r_k toggles when this disagreeing scan completes its debounce run
  assign w_flip = (r_state == UPDATE) && (r_raw[r_k] != r_keys[r_k]) &&
                  (r_cnt[r_k] == 4'(DEBOUNCE_SCANS - 1));
  assign col  = r_col;
  assign keys = r_keys;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_set   <= '0;
      r_k     <= '0;
      r_raw   <= '0;
      r_keys  <= '0;
      r_col   <= '1;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= DRIVE;
          r_col   <= {{(COLS-1){1'b1}}, 1'b0};
          r_c     <= '0;
          r_set   <= '0;
        end
        DRIVE:
          if (r_set == SW'(SETTLE_CYC - 1)) begin
            r_set                  <= '0;
            r_raw[r_c*ROWS +: ROWS] <= ~row;
            if (r_c == CW'(COLS - 1)) begin
              r_col   <= '1;
              r_state <= UPDATE;
              r_k     <= '0;
            end else begin
              r_col <= {r_col[COLS-2:0], 1'b1};
              r_c   <= r_c + 1'b1;
            end
          end else r_set <= r_set + 1'b1;
        default: begin
          r_cnt[r_k] <= (r_raw[r_k] == r_keys[r_k] || w_flip) ? 4'd0 : r_cnt[r_k] + 4'd1;
          if (w_flip) r_keys[r_k] <= ~r_keys[r_k];
          if (r_k == KW'(N - 1)) r_state <= IDLE;
          else r_k <= r_k + 1'b1;
        end
      endcase
    end
`ifdef KEY_EVENT_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;
  logic [KW:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [FW-1:0] r_fill;
  logic          r_ovf;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_drop;
  assign w_pop  = evt_valid && evt_ready;
  assign w_full = r_fill == FW'(FIFO_DEPTH);
  // a pop in the same cycle frees the slot a full FIFO needs
  assign w_push = w_flip && (!w_full || w_pop);
  assign w_drop = w_flip && w_full && !w_pop;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fill <= '0;
      r_ovf  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {r_k, ~r_keys[r_k]};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_fill <= r_fill + FW'(w_push) - FW'(w_pop);
      r_ovf  <= w_drop || (r_ovf && !ovf_clr);
    end
  assign evt_valid             = r_fill != '0;
  assign {evt_code, evt_press} = r_mem[r_rd];
  assign ovf                   = r_ovf;
`else
  logic w_unused;
  assign w_unused  = &{1'b0, evt_ready, ovf_clr, FIFO_DEPTH[0]};
  assign evt_valid = 1'b0;
  assign evt_code  = '0;
  assign evt_press = 1'b0;
  assign ovf       = 1'b0;
`endif
endmodule
